// File: rtl/controller_pkg.sv
// ============================================================================
// Module : controller_pkg
// Brief  : Shared types and constants for the controller responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_BUTTONS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// Module : sync_edge
// Brief  : 2-flop synchronizer with a registered rise/fall edge detector.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

`default_nettype wire

// File: rtl/controller_responder.sv
// ============================================================================
// Module : controller_responder
// Brief  : Serial game-controller responder (latch / pulse / data).
//          Optional per-button debounce: define BUTTON_DEBOUNCE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module controller_responder
    import controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       latch,
    input  logic       pulse,
    input  logic [7:0] buttons,
    output logic       data
);

    logic w_latch_lvl, w_latch_rise, w_latch_fall;
    logic w_pulse_lvl, w_pulse_rise, w_pulse_fall;
    logic w_unused;

    sync_edge u_latch_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (latch),
        .level_o (w_latch_lvl),
        .rise_o  (w_latch_rise),
        .fall_o  (w_latch_fall)
    );

    sync_edge u_pulse_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (pulse),
        .level_o (w_pulse_lvl),
        .rise_o  (w_pulse_rise),
        .fall_o  (w_pulse_fall)
    );

    assign w_unused = &{1'b0, w_latch_rise, w_pulse_lvl, w_pulse_fall};

    if (DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [NUM_BUTTONS-1:0] w_btn;

`ifdef BUTTON_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q;
        logic             filt_q;

        // Counter only runs while raw disagrees with the filtered level.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                filt_q <= 1'b0;
            end else if (buttons[i] == filt_q) begin
                cnt_q  <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q  <= '0;
                filt_q <= buttons[i];
            end else begin
                cnt_q  <= cnt_q + 1'b1;
            end
        end

        assign w_btn[i] = filt_q;
    end
`else
    assign w_btn = buttons;
`endif

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [NUM_BUTTONS-1:0] snap_q, snap_d;
    logic                   data_q, data_d;
    logic [2:0]             w_next_idx;

    assign w_next_idx = cnt_q + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            snap_q  <= 8'h00;
            data_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        data_d  = data_q;

        // A held latch wins over everything, including a coincident pulse edge.
        if (w_latch_lvl) begin
            state_d = LOAD;
            cnt_d   = 3'd0;
            snap_d  = w_btn;
            data_d  = ~w_btn[0];
        end else begin
            case (state_q)
                LOAD: begin
                    cnt_d  = 3'd0;
                    snap_d = w_btn;
                    data_d = ~w_btn[0];
                    if (w_latch_fall) begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_pulse_rise) begin
                        if (cnt_q == 3'd7) begin
                            state_d = DONE;
                            data_d  = 1'b1;
                        end else begin
                            cnt_d  = w_next_idx;
                            data_d = ~snap_q[w_next_idx];
                        end
                    end
                end
                IDLE, DONE: begin
                    data_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    data_d  = 1'b1;
                end
            endcase
        end
    end

    assign data = data_q;

endmodule

`default_nettype wire

// File: tb/tb_controller_responder.sv
// ============================================================================
// Module : tb_controller_responder
// Brief  : Self-checking bench for controller_responder (table + random + corners).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_controller_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       latch;
    logic       pulse;
    logic [7:0] buttons;
    logic       data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    controller_responder #(
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .latch   (latch),
        .pulse   (pulse),
        .buttons (buttons),
        .data    (data)
    );

    typedef struct {
        logic [7:0] btn;
        logic [8:0] exp;   // exp[k] = data after latch (k=0) / after k-th pulse
    } vec_t;

    vec_t vecs [5];

    // Reference: the host sees bit k active-low, then idle-high after the 8th pulse.
    function automatic logic model_bit(input logic [7:0] snap, input int k);
        if (k >= 8) return 1'b1;
        return ~snap[k];
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: data=%b expected %b", name, act, exp);
        end
    endtask

    task automatic set_buttons(input logic [7:0] b);
        @(negedge clk);
        buttons = b;
        repeat (24) @(negedge clk);
    endtask

    task automatic do_latch();
        @(negedge clk);
        latch = 1'b1;
        repeat (4) @(negedge clk);
        latch = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_pulse();
        @(negedge clk);
        pulse = 1'b1;
        repeat (4) @(negedge clk);
        pulse = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic read_model(input string name, input logic [7:0] snap);
        do_latch();
        check($sformatf("%s bit0", name), data, model_bit(snap, 0));
        for (int k = 1; k <= 8; k++) begin
            do_pulse();
            check($sformatf("%s step%0d", name, k), data, model_bit(snap, k));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rb;

        vecs[0] = '{btn: 8'h01, exp: 9'b1_1111_1110};
        vecs[1] = '{btn: 8'h80, exp: 9'b1_0111_1111};
        vecs[2] = '{btn: 8'hFF, exp: 9'b1_0000_0000};
        vecs[3] = '{btn: 8'h00, exp: 9'b1_1111_1111};
        vecs[4] = '{btn: 8'hA5, exp: 9'b1_0101_1010};

        rst     = 1'b1;
        latch   = 1'b0;
        pulse   = 1'b0;
        buttons = 8'h00;
        repeat (3) @(negedge clk);
        check("reset data", data, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Pulses in IDLE must be ignored.
        set_buttons(8'h00);
        for (int k = 0; k < 3; k++) begin
            do_pulse();
            check($sformatf("idle pulse%0d", k), data, 1'b1);
        end

        for (int v = 0; v < 5; v++) begin
            set_buttons(vecs[v].btn);
            do_latch();
            check($sformatf("vec%0d bit0", v), data, vecs[v].exp[0]);
            for (int k = 1; k <= 8; k++) begin
                do_pulse();
                check($sformatf("vec%0d step%0d", v, k), data, vecs[v].exp[k]);
            end
        end

        for (int r = 0; r < 6; r++) begin
            rb = 8'($urandom);
            set_buttons(rb);
            read_model($sformatf("rand%0d(%h)", r, rb), rb);
        end

        // Restart mid-transfer; buttons changing in SHIFT must not show up.
        set_buttons(8'h01);
        do_latch();
        for (int k = 1; k <= 3; k++) do_pulse();
        check("restart pre-change", data, model_bit(8'h01, 3));
        set_buttons(8'hFF);
        check("shift ignores buttons", data, model_bit(8'h01, 3));
        read_model("restart FF", 8'hFF);

        // Asynchronous reset mid-shift.
        set_buttons(8'h10);
        do_latch();
        for (int k = 1; k <= 4; k++) do_pulse();
        check("pre-reset bit4", data, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async reset data", data, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_pulse();
            check($sformatf("post-reset pulse%0d", k), data, 1'b1);
        end
        read_model("post-reset read", 8'h10);

        // Latch and pulse rising together while in SHIFT: LOAD wins.
        set_buttons(8'h02);
        do_latch();
        @(negedge clk);
        #2;
        latch = 1'b1;
        pulse = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("latch beats pulse edge", data, 1'b1);
        repeat (4) @(negedge clk);
        latch = 1'b0;
        pulse = 1'b0;
        repeat (4) @(negedge clk);
        check("same-cycle bit0", data, model_bit(8'h02, 0));
        for (int k = 1; k <= 8; k++) begin
            do_pulse();
            check($sformatf("same-cycle step%0d", k), data, model_bit(8'h02, k));
        end

        // Pin-to-data latency: visible on the 3rd clk edge, not the 2nd.
        set_buttons(8'h01);
        do_latch();
        check("latency bit0", data, 1'b0);
        @(negedge clk);
        #2 pulse = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("latency edge2 holds", data, 1'b0);
        @(posedge clk);
        #1 check("latency edge3 updates", data, 1'b1);
        repeat (4) @(negedge clk);
        pulse = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 2; k <= 8; k++) begin
            do_pulse();
            check($sformatf("latency step%0d", k), data, model_bit(8'h01, k));
        end

`ifdef BUTTON_DEBOUNCE_EN
        set_buttons(8'h00);
        @(negedge clk);
        buttons = 8'h08;
        repeat (10) @(negedge clk);
        buttons = 8'h00;
        repeat (24) @(negedge clk);
        read_model("glitch rejected", 8'h00);

        @(negedge clk);
        buttons = 8'h08;
        repeat (20) @(negedge clk);
        buttons = 8'h00;
        read_model("press captured", 8'h08);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/controller_responder.md
CONTROLLER_RESPONDER -- requirements
Module: controller_responder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16; a button input must be stable for this many clk cycles before it is accepted (used only with BUTTON_DEBOUNCE_EN).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state is clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port latch, input, 1 bit: host latch strobe, asynchronous to clk.
REQ-005 The block SHALL have port pulse, input, 1 bit: host shift clock, asynchronous to clk.
REQ-006 The block SHALL have port buttons, input, 8 bits: raw button levels, 1 = pressed; bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
REQ-007 The block SHALL have port data, output, 1 bit: serial button stream to the host, active-low (0 = pressed), registered.

Function
REQ-008 latch and pulse SHALL each pass through a 2-flop synchronizer followed by a registered edge detector.
REQ-009 The block SHALL implement a state machine with states IDLE, LOAD, SHIFT and DONE.
REQ-010 In any state, a synchronized latch level of 1 SHALL force LOAD; this overrides any pulse edge in the same cycle and aborts SHIFT.
REQ-011 In LOAD, every cycle, the snapshot register SHALL be loaded with the button value (raw buttons, or the filtered value under BUTTON_DEBOUNCE_EN), and data SHALL be driven with ~snapshot[0].
REQ-012 A synchronized latch falling edge in LOAD SHALL cause a transition to SHIFT with the bit counter at 0; the snapshot is frozen and data holds ~snapshot[0].
REQ-013 In SHIFT, each synchronized pulse rising edge SHALL increment the 3-bit counter and update data to ~snapshot[counter+1] on that same clk edge.
REQ-014 When the counter is 7 and a pulse rising edge occurs, the block SHALL enter DONE and drive data = 1.
REQ-015 In IDLE and DONE, pulse edges SHALL be ignored and data SHALL be held at 1.
REQ-016 A host edge at a pin SHALL be reflected on data on the 3rd rising clk edge after that edge is first sampled; pulse high and low phases each shorter than 2 clk periods are out of specification.
REQ-017 A buttons change during SHIFT or DONE SHALL NOT affect data until the next LOAD.

Reset
REQ-018 While rst = 1, the block SHALL hold state = IDLE, data = 1, counter = 0, snapshot = 8'h00, all synchronizer and edge flops at 0, and all debounce counters at 0 with filtered buttons at 0.
REQ-019 Reset asserted mid-SHIFT SHALL abort the transfer; after release, the block SHALL wait in IDLE for the next latch.

Configuration
REQ-020 When macro BUTTON_DEBOUNCE_EN is defined, each button bit SHALL have its own saturating counter; a filtered bit SHALL change only after the raw bit has differed from it for DEBOUNCE_CYCLES consecutive clk cycles, and any intervening match SHALL reset that counter.
REQ-021 When BUTTON_DEBOUNCE_EN is undefined, the snapshot SHALL load the raw buttons value directly, with no debounce logic and no added latency.

Structure
REQ-022 A package controller_pkg SHALL hold: the state_t enum (IDLE, LOAD, SHIFT, DONE), NUM_BUTTONS = 8, and the button index constants BTN_A through BTN_RIGHT.
REQ-023 A single sub-module sync_edge SHALL implement the 2-flop synchronizer plus the rise/fall detector; it is instantiated once for latch and once for pulse.

Verification
REQ-024 The bench SHALL cover: reset, then buttons = 8'b0000_0001, a latch pulse, then 8 pulses -> data sequence 0,1,1,1,1,1,1,1, then 1 after the 8th pulse.
REQ-025 The bench SHALL cover: buttons = 8'b1000_0000, full read -> data is 1 for bits 0–6 and 0 on bit 7, then 1 in DONE.
REQ-026 The bench SHALL cover: latch re-asserted after 3 pulses with buttons changed to 8'hFF -> the transfer restarts and data = 0 for all 8 bits.
REQ-027 The bench SHALL cover: rst asserted after 4 pulses -> data = 1 immediately; extra pulses without a latch keep data = 1.
REQ-028 The bench SHALL cover: pulse edges while IDLE, and latch and pulse rising in the same cycle -> no shift, and LOAD wins.
REQ-029 The bench SHALL cover, with BUTTON_DEBOUNCE_EN and DEBOUNCE_CYCLES = 16: a 10-cycle glitch on buttons[3] is not captured, while a 20-cycle press is captured (data = 0 on bit 3).
